// File: rtl/nearpm_pkg.sv
// Shared NearPM definitions: dispatch FSM states, default widths and the
// thread-ID type used by both the dispatch stage and the scheduler.
package nearpm_pkg;

  localparam int CMD_W_DEF       = 64;
  localparam int DEPTH_DEF       = 8;
  localparam int NUM_THREADS_DEF = 4;
  localparam int TID_W_DEF       = $clog2(NUM_THREADS_DEF);

  // Thread ID at the default thread count.
  typedef logic [TID_W_DEF-1:0] tid_t;

  // Dispatch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/nearpm_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head and exact occupancy.
// A push while full is refused even if a pop happens in the same cycle.
module nearpm_sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && (r_count != FULL_CNT);
  assign w_do_pop  = i_pop && (r_count != '0);

  // Storage; the head is only consumed while count > 0, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count is exact.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/nearpm_cmd_dispatch.sv
// NearPM command staging and dispatch. Commands queue in a FIFO; a start
// pulse snapshots the occupancy and issues exactly that many commands to
// free scheduler threads, round-robin from the last issued thread. done
// pulses once every issued command has reported completion.
//
// Handshake: a command transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid is 1 it stays 1, and out_cmd/out_tid
// stay constant, until that transfer; out_ready may be high before out_valid.
module nearpm_cmd_dispatch
  import nearpm_pkg::*;
#(
  parameter int CMD_W       = CMD_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int NUM_THREADS = NUM_THREADS_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CMD_W-1:0]               in_cmd,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CMD_W-1:0]               out_cmd,
  output logic [$clog2(NUM_THREADS)-1:0] out_tid,
  input  logic [NUM_THREADS-1:0]         thread_done,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(DEPTH):0]         count,
  output state_t                         dbg_state
);

  localparam int TID_W = $clog2(NUM_THREADS);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_remaining;
  logic [NUM_THREADS-1:0] r_thread_busy;
  logic [TID_W-1:0]       r_rr_ptr;
  logic                   r_hold;
  logic [TID_W-1:0]       r_hold_tid;
  logic                   r_done;

  logic [CMD_W-1:0]       w_head;
  logic [CNT_W-1:0]       w_count;
  logic                   w_full;
  logic [TID_W-1:0]       w_scan_idx;
  logic [TID_W-1:0]       w_alloc_tid;
  logic                   w_any_free;
  logic                   w_out_valid;
  logic [TID_W-1:0]       w_out_tid;
  logic                   w_handshake;
  logic [NUM_THREADS-1:0] w_issue_mask;

  nearpm_sync_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (in_valid),
    .i_wdata (in_cmd),
    .i_pop   (w_handshake),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // First free thread scanning upward from rr_ptr with wrap (registered busy only).
  always_comb begin
    w_alloc_tid = r_rr_ptr;
    w_any_free  = 1'b0;
    w_scan_idx  = r_rr_ptr;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_scan_idx = r_rr_ptr + TID_W'(i);
      if (!w_any_free && !r_thread_busy[w_scan_idx]) begin
        w_any_free  = 1'b1;
        w_alloc_tid = w_scan_idx;
      end
    end
  end

  // Offer conditions; a held offer keeps its thread ID until it transfers.
  always_comb begin
    w_out_valid  = (r_state == ST_RUN) && (w_count != '0) &&
                   (r_remaining != '0) && (r_hold || w_any_free);
    w_out_tid    = r_hold ? r_hold_tid : w_alloc_tid;
    w_handshake  = w_out_valid && out_ready;
    w_issue_mask = '0;
    if (w_handshake) w_issue_mask[w_out_tid] = 1'b1;
  end

  // Lock the offered thread ID while the scheduler applies backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold     <= 1'b0;
      r_hold_tid <= '0;
    end else begin
      r_hold     <= w_out_valid && !out_ready;
      r_hold_tid <= w_out_tid;
    end
  end

  // Per-thread busy bits and the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_thread_busy <= '0;
      r_rr_ptr      <= '0;
    end else begin
      r_thread_busy <= (r_thread_busy & ~thread_done) | w_issue_mask;
      if (w_handshake) r_rr_ptr <= w_out_tid + TID_W'(1);
    end
  end

  // Batch FSM: snapshot occupancy on start, issue, then wait for completions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_remaining <= w_count;
            if (w_count != '0) r_state <= ST_RUN;
            else               r_done  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_handshake) begin
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_thread_busy == '0) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = w_out_valid;
  assign out_cmd   = w_out_valid ? w_head : '0;
  assign out_tid   = w_out_tid;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign count     = w_count;
  assign dbg_state = r_state;

endmodule

// File: doc/nearpm_cmd_dispatch.md
# nearpm_cmd_dispatch

Command staging and dispatch stage that sits directly upstream of the multi-thread scheduler. Buffers incoming NearPM commands in a small FIFO and, on a `start` pulse, issues exactly the commands present at that moment to free scheduler threads, tagging each with a thread ID. Tracks per-thread busy state and pulses `done` once every issued command has reported completion.

## Interface
- `CMD_W`, 64, command word width
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `NUM_THREADS`, 4, scheduler thread slots; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  one-cycle pulse; begins a dispatch batch
- `in_valid`  in  1  upstream command valid
- `in_ready`  out  1  FIFO not full
- `in_cmd`  in  CMD_W  command word
- `out_valid`  out  1  command offered to scheduler
- `out_ready`  in  1  scheduler accepts
- `out_cmd`  out  CMD_W  FIFO head
- `out_tid`  out  log2(NUM_THREADS)  allocated thread
- `thread_done`  in  NUM_THREADS  per-thread completion pulses
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle batch-complete pulse
- `count`  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO: push on `in_valid && in_ready`; `in_ready = (count != DEPTH)`; no pass-through when full, even if pop occurs that cycle. Pointers wrap modulo DEPTH; `count` is exact, 0..DEPTH.
- FSM states IDLE, RUN, WAIT.
  - IDLE: `start` latches `remaining = count` (occupancy before any same-cycle push). remaining>0 → RUN; remaining=0 → `done` pulse next cycle, stay IDLE.
  - RUN: `out_valid = (count>0) && (remaining>0) && any thread free`. Handshake pops FIFO, sets `thread_busy[out_tid]`, decrements `remaining`, advances `rr_ptr` to `out_tid+1` mod NUM_THREADS. remaining reaches 0 → WAIT.
  - WAIT: when `thread_busy == 0` → IDLE with `done` pulse on the transition.
- `start` outside IDLE ignored. Commands pushed after `start` stay queued for the next batch.
- Thread allocation: first free thread searching upward from `rr_ptr` with wrap, using registered `thread_busy`. Once `out_valid` rises, `out_tid` and `out_cmd` are locked until the handshake.
- `thread_done[i]` clears `thread_busy[i]`; pulses for non-busy threads are ignored. Done and issue to the same thread in one cycle cannot occur, because allocation sees only registered busy bits.
- Reset, including mid-batch: FIFO empty, state IDLE, `thread_busy=0`, `rr_ptr=0`, `remaining=0`; in-flight commands are dropped.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_cmd=0`, `out_tid=0`, `busy=0`, `done=0`, `count=0`.
- `start` at edge t → `busy=1` and earliest `out_valid` at t+1.
- Back-to-back issue: one command per cycle while threads are free and `out_ready=1`.
- `out_valid` never drops without a handshake (valid/ready rule); `out_ready` may be asserted before valid.
- `thread_done` at edge t → thread allocatable from t+1.
- `done` asserts on the cycle after the last busy bit clears, then `busy=0` on the same edge.

## Structure
- Shared package `nearpm_pkg`: FSM state enum, default `CMD_W`/`NUM_THREADS`, `tid_t` typedef (also used by the scheduler).
- One sub-module: `nearpm_sync_fifo` (DEPTH×CMD_W, push/pop/count, first-word fall-through head). The FSM, allocator and busy tracking live at top level.

## Test plan
- Reset and idle: check all reset values. `start` with an empty FIFO → `done` pulses 1 cycle later, `busy` never asserts.
- Basic batch: push 3 commands `0xA1..0xA3`, `start`, `out_ready=1` → issued with tid 0,1,2 on consecutive cycles; `thread_done=4'b0111` → `done` pulses once, `busy` drops.
- Thread starvation: push 6 commands, `NUM_THREADS=4`, no `thread_done` → 4 issued, `out_valid=0`. Pulse `thread_done[2]` → 5th command issues with `out_tid=2` the next cycle.
- Full and simultaneous: fill 8 → `in_ready=0`. Push attempted while popping → rejected. Push issued during RUN → not in the batch (`remaining` counts only the original 8).
- Backpressure: `out_ready=0` for 5 cycles → `out_valid`, `out_cmd`, `out_tid` stable. A `thread_done` for a lower thread meanwhile does not change `out_tid`.
- Mid-batch reset: assert `reset` after 2 of 4 issues → all outputs return to reset values asynchronously; a later batch of 1 gets `out_tid=0`.
